// File: rtl/bsg_fsb_pkg.sv
// rtl/bsg_fsb_pkg.sv - shared FSB word width and word type for the hop stages
package bsg_fsb_pkg;

  localparam int fsb_width_gp = 16;

  typedef logic [fsb_width_gp-1:0] fsb_word_t;

endpackage

// File: rtl/bsg_front_side_bus_hop_out_no_fc_if.sv
// rtl/bsg_front_side_bus_hop_out_no_fc_if.sv - pass-through, local injection and next-hop signals
interface bsg_front_side_bus_hop_out_no_fc_if
  import bsg_fsb_pkg::*;
#(
  parameter int width_p = fsb_width_gp
);

  logic [width_p-1:0] pass_data_i;
  logic               pass_v_i;
  logic [width_p-1:0] local_data_i;
  logic               local_v_i;
  logic               local_ready_o;
  logic [width_p-1:0] data_o;
  logic               v_o;
  logic               local_sent_o;
  logic               starve_o;

  modport master (
    output pass_data_i, pass_v_i, local_data_i, local_v_i,
    input  local_ready_o, data_o, v_o, local_sent_o, starve_o
  );

  modport slave (
    input  pass_data_i, pass_v_i, local_data_i, local_v_i,
    output local_ready_o, data_o, v_o, local_sent_o, starve_o
  );

endinterface

// File: rtl/bsg_fsb_local_fifo.sv
// rtl/bsg_fsb_local_fifo.sv - local injection FIFO with wrap-bit pointers
module bsg_fsb_local_fifo
  import bsg_fsb_pkg::*;
#(
  parameter int width_p = fsb_width_gp,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               enq,
  input  logic [width_p-1:0] enq_data,
  input  logic               deq,
  output logic [width_p-1:0] head,
  output logic               full,
  output logic               empty
);

  localparam int lg_els_lp = $clog2(els_p);
  localparam int ptr_w_lp  = lg_els_lp + 1;

  logic [ptr_w_lp-1:0] rd_r, wr_r;
  logic [width_p-1:0]  mem_r [els_p];

  // Storage is deliberately left out of reset; only the pointers define occupancy.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_r[wr_r[lg_els_lp-1:0]] <= enq_data;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_r <= '0;
      wr_r <= '0;
    end else begin
      if (enq) wr_r <= wr_r + ptr_w_lp'(1);
      if (deq) rd_r <= rd_r + ptr_w_lp'(1);
    end
  end

  assign empty = (rd_r == wr_r);
  assign full  = (rd_r[lg_els_lp] != wr_r[lg_els_lp])
              && (rd_r[lg_els_lp-1:0] == wr_r[lg_els_lp-1:0]);
  assign head  = mem_r[rd_r[lg_els_lp-1:0]];

endmodule

// File: rtl/bsg_front_side_bus_hop_out_no_fc.sv
// rtl/bsg_front_side_bus_hop_out_no_fc.sv - FSB hop output merge: pass-through wins, local fills idle slots
module bsg_front_side_bus_hop_out_no_fc
  import bsg_fsb_pkg::*;
#(
  parameter int width_p        = fsb_width_gp,
  parameter int local_els_p    = 4,
  parameter int starve_limit_p = 64
) (
  input  logic clk_i,
  input  logic reset_n_i,
  bsg_front_side_bus_hop_out_no_fc_if.slave bus
);

  localparam int cnt_w_lp = $clog2(starve_limit_p + 1);
  localparam logic [cnt_w_lp-1:0] limit_lp = cnt_w_lp'(starve_limit_p);

  logic               enq, deq, full, empty;
  logic [width_p-1:0] head;
  logic [width_p-1:0] data_r;
  logic               v_r, sent_r, starve_r;
  logic [cnt_w_lp-1:0] cnt_r, cnt_n;

  // Full comes from registered pointers, so ready has no path from any input.
  assign enq = bus.local_v_i & ~full;
  assign deq = ~bus.pass_v_i & ~empty;

  bsg_fsb_local_fifo #(
    .width_p (width_p),
    .els_p   (local_els_p)
  ) fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .enq       (enq),
    .enq_data  (bus.local_data_i),
    .deq       (deq),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      data_r <= '0;
      v_r    <= 1'b0;
      sent_r <= 1'b0;
    end else if (bus.pass_v_i) begin
      data_r <= bus.pass_data_i;
      v_r    <= 1'b1;
      sent_r <= 1'b0;
    end else if (!empty) begin
      data_r <= head;
      v_r    <= 1'b1;
      sent_r <= 1'b1;
    end else begin
      v_r    <= 1'b0;
      sent_r <= 1'b0;
    end
  end

  // Counts only cycles where a waiting local word loses to pass-through traffic.
  always_comb begin
    cnt_n = cnt_r;
    if (deq || empty) begin
      cnt_n = '0;
    end else if (bus.pass_v_i && (cnt_r != limit_lp)) begin
      cnt_n = cnt_r + cnt_w_lp'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_r    <= '0;
      starve_r <= 1'b0;
    end else begin
      cnt_r    <= cnt_n;
      starve_r <= (cnt_n == limit_lp);
    end
  end

  assign bus.local_ready_o = ~full;
  assign bus.data_o        = data_r;
  assign bus.v_o           = v_r;
  assign bus.local_sent_o  = sent_r;
  assign bus.starve_o      = starve_r;

endmodule

// File: tb/tb_bsg_front_side_bus_hop_out_no_fc.sv
// tb/tb_bsg_front_side_bus_hop_out_no_fc.sv - scoreboard bench for the FSB hop output merge stage
module tb_bsg_front_side_bus_hop_out_no_fc;
  import bsg_fsb_pkg::*;

  logic clk_i = 1'b0;
  logic reset_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  bsg_front_side_bus_hop_out_no_fc_if #(.width_p(fsb_width_gp)) bus_if ();

  bsg_front_side_bus_hop_out_no_fc #(
    .width_p        (fsb_width_gp),
    .local_els_p    (4),
    .starve_limit_p (8)
  ) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .bus       (bus_if.slave)
  );

  int checks = 0;
  int errors = 0;
  fsb_word_t pass_q[$];
  fsb_word_t local_q[$];
  logic      last_pass_v = 1'b0;
  logic      taken;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  always @(posedge clk_i) begin
    last_pass_v = reset_n_i & bus_if.pass_v_i;
  end

  // Monitor: pops the matching queue whenever the DUT presents a word.
  always @(negedge clk_i) begin
    fsb_word_t exp_w;
    if (reset_n_i) begin
      if (last_pass_v) begin
        check("pass_latency_v", 32'(bus_if.v_o), 32'd1);
        check("pass_latency_not_local", 32'(bus_if.local_sent_o), 32'd0);
      end
      if (bus_if.v_o) begin
        if (bus_if.local_sent_o) begin
          if (local_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL local_unexpected: got 0x%0h, expected no local word", bus_if.data_o);
          end else begin
            exp_w = local_q.pop_front();
            check("local_data", 32'(bus_if.data_o), 32'(exp_w));
          end
        end else begin
          if (pass_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pass_unexpected: got 0x%0h, expected no pass word", bus_if.data_o);
          end else begin
            exp_w = pass_q.pop_front();
            check("pass_data", 32'(bus_if.data_o), 32'(exp_w));
          end
        end
      end else begin
        check("sent_without_valid", 32'(bus_if.local_sent_o), 32'd0);
      end
    end
  end

  // One clock of stimulus; entered and left at posedge+1.
  task automatic cycle(input logic pv, input fsb_word_t pd, input logic lv, input fsb_word_t ld,
                       output logic tk);
    bus_if.pass_v_i     = pv;
    bus_if.pass_data_i  = pd;
    bus_if.local_v_i    = lv;
    bus_if.local_data_i = ld;
    if (pv) pass_q.push_back(pd);
    @(negedge clk_i);
    tk = lv & bus_if.local_ready_o;
    if (tk) local_q.push_back(ld);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.pass_v_i     = 1'b0;
    bus_if.pass_data_i  = '0;
    bus_if.local_v_i    = 1'b0;
    bus_if.local_data_i = '0;

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_v", 32'(bus_if.v_o), 32'd0);
    check("rst_data", 32'(bus_if.data_o), 32'd0);
    check("rst_ready", 32'(bus_if.local_ready_o), 32'd1);
    check("rst_starve", 32'(bus_if.starve_o), 32'd0);
    reset_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Pass-through wins over a simultaneous local enqueue
    cycle(1'b1, 16'h1234, 1'b1, 16'hBEEF, taken);
    check("pass_data_o", 32'(bus_if.data_o), 32'h1234);
    check("pass_v_o", 32'(bus_if.v_o), 32'd1);
    check("pass_sent", 32'(bus_if.local_sent_o), 32'd0);
    cycle(1'b0, 16'h0, 1'b0, 16'h0, taken);
    check("beef_data", 32'(bus_if.data_o), 32'hBEEF);
    check("beef_sent", 32'(bus_if.local_sent_o), 32'd1);

    // Idle-link local latency: two cycles
    cycle(1'b0, 16'h0, 1'b1, 16'hA5A5, taken);
    check("a5_first_edge_v", 32'(bus_if.v_o), 32'd0);
    cycle(1'b0, 16'h0, 1'b0, 16'h0, taken);
    check("a5_v", 32'(bus_if.v_o), 32'd1);
    check("a5_data", 32'(bus_if.data_o), 32'hA5A5);
    check("a5_sent", 32'(bus_if.local_sent_o), 32'd1);
    cycle(1'b0, 16'h0, 1'b0, 16'h0, taken);
    check("idle_v", 32'(bus_if.v_o), 32'd0);
    check("idle_hold_data", 32'(bus_if.data_o), 32'hA5A5);

    // Fill the FIFO under continuous pass traffic
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, fsb_word_t'(16'h1000 + i), 1'b1, fsb_word_t'(i), taken);
      check("fill_taken", 32'(taken), 32'd1);
    end
    check("full_ready", 32'(bus_if.local_ready_o), 32'd0);
    cycle(1'b1, 16'h1005, 1'b1, 16'h0005, taken);
    check("fifth_ready", 32'(bus_if.local_ready_o), 32'd0);
    bus_if.local_v_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b0, 16'h0, 1'b0, 16'h0, taken);
      check("drain_sent", 32'(bus_if.local_sent_o), 32'd1);
      check("drain_data", 32'(bus_if.data_o), 32'(i));
    end
    check("drain_ready", 32'(bus_if.local_ready_o), 32'd1);

    // Starvation: one waiting word blocked for eight edges
    cycle(1'b1, 16'h2000, 1'b1, 16'h00C5, taken);
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, fsb_word_t'(16'h2000 + i), 1'b0, 16'h0, taken);
      check("starve_ramp", 32'(bus_if.starve_o), (i == 8) ? 32'd1 : 32'd0);
    end
    cycle(1'b0, 16'h0, 1'b0, 16'h0, taken);
    check("starve_sent", 32'(bus_if.local_sent_o), 32'd1);
    check("starve_data", 32'(bus_if.data_o), 32'h00C5);
    check("starve_clear", 32'(bus_if.starve_o), 32'd0);

    // Asynchronous reset in the middle of a burst
    cycle(1'b1, 16'h3001, 1'b1, 16'h0031, taken);
    cycle(1'b1, 16'h3002, 1'b0, 16'h0, taken);
    check("burst_v", 32'(bus_if.v_o), 32'd1);
    #3;
    reset_n_i = 1'b0;
    #1;
    check("async_rst_v", 32'(bus_if.v_o), 32'd0);
    check("async_rst_data", 32'(bus_if.data_o), 32'd0);
    check("async_rst_ready", 32'(bus_if.local_ready_o), 32'd1);
    bus_if.pass_v_i  = 1'b0;
    bus_if.local_v_i = 1'b0;
    pass_q.delete();
    local_q.delete();
    repeat (2) @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("post_rst_v", 32'(bus_if.v_o), 32'd0);

    // Random traffic against the scoreboard
    for (int n = 0; n < 10000; n++) begin
      cycle(($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0, fsb_word_t'($urandom),
            1'($urandom_range(0, 1)), fsb_word_t'($urandom), taken);
    end
    bus_if.local_v_i = 1'b0;
    for (int n = 0; n < 10 && local_q.size() != 0; n++) begin
      cycle(1'b0, 16'h0, 1'b0, 16'h0, taken);
    end
    cycle(1'b0, 16'h0, 1'b0, 16'h0, taken);
    check("final_local_q_empty", 32'(local_q.size()), 32'd0);
    check("final_pass_q_empty", 32'(pass_q.size()), 32'd0);
    check("final_ready", 32'(bus_if.local_ready_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
